set_bit_enum: RTL and testbench
===============================

SET_BIT_ENUM -- requirements
Module: set_bit_enum

Interface
REQ-001 SHALL have parameter W, default 64, input word width; power of two, 8..64.
REQ-002 SHALL have parameter IDX_W, default $clog2(W), index width; derived, not overridden.
REQ-003 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have in_valid  input  1  input word offered.
REQ-006 SHALL have in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have in_data  input  W  word to enumerate.
REQ-008 SHALL have out_valid  output  1  index beat offered.
REQ-009 SHALL have out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have out_idx  output  IDX_W  bit position of the current set bit.
REQ-011 SHALL have out_ord  output  IDX_W+1  0-based ordinal of the beat within its word.
REQ-012 SHALL have out_last  output  1  final beat of the word.
REQ-013 SHALL have out_empty  output  1  word had no set bits; the beat carries no index.

Function
REQ-014 SHALL implement FSM {IDLE, EMIT}; reset state IDLE.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid 0.
REQ-016 On in_valid&&in_ready, SHALL latch in_data into pending register pend, clear ord to 0, enter EMIT; first beat valid the next cycle (latency 1).
REQ-017 In EMIT, out_valid SHALL be 1; out_idx = index of lowest set bit of pend; out_ord = ord.
REQ-018 out_last SHALL be 1 when pend has at most one set bit.
REQ-019 When pend == 0 in EMIT, SHALL emit exactly one beat with out_empty=1, out_last=1, out_idx=0, out_ord=0.
REQ-020 On out_valid&&out_ready&&!out_last, SHALL clear pend's lowest set bit (pend & (pend-1)) and increment ord; one beat per cycle sustained.
REQ-021 On out_valid&&out_ready&&out_last, SHALL return to IDLE unless a new word is accepted that same cycle.
REQ-022 in_ready SHALL be 1 in EMIT only when out_last&&out_ready (back-to-back words, no bubble); a word accepted then SHALL overwrite pend and stay in EMIT with ord reset to 0.
REQ-023 While out_valid&&!out_ready, all out_* SHALL remain stable.
REQ-024 For any word, the number of beats SHALL equal max(1, popcount(word)); on the last non-empty beat out_ord+1 = popcount.
REQ-025 Indices within a word SHALL be strictly ascending.
REQ-026 Bit W-1 set alone SHALL yield out_idx = W-1 without width overflow; all-ones word SHALL yield out_ord reaching W-1.

Reset
REQ-027 On rst_n low, SHALL asynchronously force state IDLE, pend 0, ord 0, out_valid 0, in_ready 0 while rst_n is low, out_idx 0, out_ord 0, out_last 0, out_empty 0.
REQ-028 Reset mid-word SHALL discard remaining beats; no beat after release until a new word is accepted.
REQ-029 in_ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-030 Package set_bit_enum_pkg SHALL hold the state enum typedef and localparams for default W, IDX_W, and ord width.
REQ-031 Lowest-set-bit index SHALL be a combinational sub-module lsb_index (W in, IDX_W idx out, zero flag out).
REQ-032 Outputs SHALL derive from registered pend/ord/state through lsb_index only; no in_data-to-out_* combinational path.

Verification
REQ-033 Word 0x0 -> one beat: empty=1, last=1, idx=0, ord=0; then IDLE.
REQ-034 Word 0x1 then 0x8000_0000_0000_0000 back-to-back, out_ready=1 -> beats idx 0 (last) then idx 63 (last), no idle cycle between.
REQ-035 Word 0x0000_0000_0000_00A5 -> idx 0,2,5,7; ord 0..3; last only on idx 7.
REQ-036 All-ones word with out_ready toggling 1/0 -> 64 beats, idx=ord=0..63, outputs stable on stalled cycles.
REQ-037 rst_n pulsed low after 2 beats of 0xFF -> out_valid 0 immediately; no further beats after release.
REQ-038 10 random words -> beat count equals popcount64 reference model, OR of emitted indices reconstructs the word.

Source files
------------

// File: rtl/set_bit_enum_pkg.sv
// Shared types and default sizing for the set-bit enumerator.
// The state enum lives here so the top and any future siblings agree on it.
package set_bit_enum_pkg;

  localparam int DEFAULT_W     = 64;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_W);
  localparam int DEFAULT_ORD_W = DEFAULT_IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage : set_bit_enum_pkg

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 in vec,
// plus a flag for the all-zero case (idx is 0 then).
module lsb_index #(
  parameter int W     = 64,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first; otherwise a path
    // that skips the assignment would infer a latch.
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign zero = (vec == '0);

endmodule : lsb_index

// File: rtl/set_bit_enum.sv
// Enumerates the set bits of an input word, one index beat per cycle, lowest
// bit first, with ordinal, last and empty-word flags on a valid/ready stream.
module set_bit_enum
  import set_bit_enum_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_ord,
  output logic             out_last,
  output logic             out_empty
);

  localparam int ORD_W = IDX_W + 1;

  state_t             state;
  logic [W-1:0]       pend;
  logic [ORD_W-1:0]   ord;

  logic [IDX_W-1:0]   lsb_idx;
  logic               pend_zero;
  logic [W-1:0]       pend_rest;
  logic               emit;
  logic               accept;
  logic               advance;

  lsb_index #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_lsb_index (
    .vec  (pend),
    .idx  (lsb_idx),
    .zero (pend_zero)
  );

  // pend with its lowest set bit removed; zero means the current beat is the last.
  assign pend_rest = pend & (pend - W'(1));
  assign emit      = (state == EMIT);

  // Outputs come only from registered pend/ord/state, never from in_data.
  assign out_valid = emit;
  assign out_last  = emit && (pend_rest == '0);
  assign out_empty = emit && pend_zero;
  assign out_idx   = emit ? lsb_idx : '0;
  assign out_ord   = emit ? ord     : '0;

  // Held low during reset; in EMIT a new word is taken only as the last beat leaves,
  // which gives back-to-back words with no idle cycle.
  assign in_ready  = rst_n && (!emit || (out_last && out_ready));

  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      state <= IDLE;
      pend  <= '0;
      ord   <= '0;
    end else if (accept) begin
      state <= EMIT;
      pend  <= in_data;
      ord   <= '0;
    end else if (advance) begin
      if (out_last) begin
        state <= IDLE;
        pend  <= '0;
        ord   <= '0;
      end else begin
        pend  <= pend_rest;
        ord   <= ord + ORD_W'(1);
      end
    end
  end

endmodule : set_bit_enum

// File: tb/tb_set_bit_enum.sv
// Self-checking bench for set_bit_enum: directed words plus random words, each
// checked beat-by-beat against a queue of expected beats built from the word.
module tb_set_bit_enum;

  localparam int W      = 64;
  localparam int IDX_W  = 6;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_ord;
  logic             out_last;
  logic             out_empty;

  set_bit_enum #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_ord   (out_ord),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ord;
    bit last;
    bit empty;
  } beat_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  word_q[$];   // words waiting to be offered
  logic [63:0]  acc_q[$];    // words accepted, not yet fully emitted
  beat_t        exp_q[$];    // expected beats still to come
  logic [63:0]  or_acc;
  int           beat_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input int idx, input int ord, input bit last, input bit empty);
    return (64'(idx) << 9) | (64'(ord) << 2) | (64'(last) << 1) | 64'(empty);
  endfunction

  // Expected beats straight from the rules: ascending set-bit positions, or one empty beat.
  task automatic push_beats(input logic [63:0] w);
    int n;
    int k;
    beat_t b;
    n = $countones(w);
    if (n == 0) begin
      b = '{idx: 0, ord: 0, last: 1'b1, empty: 1'b1};
      exp_q.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < 64; i++) begin
        if (w[i]) begin
          b = '{idx: i, ord: k, last: (k == n - 1), empty: 1'b0};
          exp_q.push_back(b);
          k++;
        end
      end
    end
  endtask

  // mode 0: out_ready held high, 1: toggles 1/0, 2: random. stop_after > 0 returns
  // after that many beats have been handed over.
  task automatic run(input int mode, input int stop_after);
    int          cyc = 0;
    int          beats = 0;
    bit          stalled = 1'b0;
    bit          exp_v;
    bit          exp_rdy;
    logic [63:0] got;
    logic [63:0] prev = '0;
    logic [63:0] w;
    beat_t       b;
    while (word_q.size() > 0 || exp_q.size() > 0) begin
      in_valid  = (word_q.size() > 0);
      in_data   = in_valid ? word_q[0] : {$urandom, $urandom};
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      exp_v   = (exp_q.size() > 0);
      exp_rdy = !exp_v || (exp_q.size() == 1 && out_ready);
      got     = pack(int'(out_idx), int'(out_ord), out_last, out_empty);
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (exp_v) begin
        b = exp_q[0];
        check("beat", got, pack(b.idx, b.ord, b.last, b.empty));
      end
      if (stalled) check("stall_hold", got, prev);
      stalled = out_valid && !out_ready;
      prev    = got;
      // Word-level reconstruction from what the DUT actually emitted.
      if (out_valid && out_ready) begin
        beats++;
        beat_cnt++;
        if (!out_empty) or_acc = or_acc | (64'd1 << out_idx);
        if (out_last) begin
          if (acc_q.size() == 0) begin
            check("spurious_last", 64'(beat_cnt), 64'd0);
          end else begin
            w = acc_q.pop_front();
            check("beat_count", 64'(beat_cnt), 64'((($countones(w) > 0) ? $countones(w) : 1)));
            check("or_rebuild", or_acc, w);
          end
          or_acc   = '0;
          beat_cnt = 0;
        end
      end
      if (exp_v && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        w = word_q.pop_front();
        acc_q.push_back(w);
        push_beats(w);
      end
      if (stop_after > 0 && beats >= stop_after) return;
      cyc++;
      if (cyc > BUDGET) begin
        check("timeout", 64'(cyc), 64'(BUDGET));
        word_q.delete();
        exp_q.delete();
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_check(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_beat", pack(int'(out_idx), int'(out_ord), out_last, out_empty), 64'd0);
  endtask

  task automatic clear_model();
    word_q.delete();
    acc_q.delete();
    exp_q.delete();
    or_acc   = '0;
    beat_cnt = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_model();

    #12;
    check_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_check(2);

    // Zero word: a single empty beat, then idle.
    word_q.push_back(64'h0);
    run(0, 0);
    idle_check(1);

    // Single bit 0 then single bit 63, back-to-back.
    word_q.push_back(64'h1);
    word_q.push_back(64'h8000_0000_0000_0000);
    run(0, 0);
    idle_check(1);

    word_q.push_back(64'h0000_0000_0000_00A5);
    run(0, 0);
    idle_check(1);

    // All ones with a toggling consumer.
    word_q.push_back('1);
    run(1, 0);
    idle_check(1);

    // Reset in the middle of a word.
    word_q.push_back(64'hFF);
    run(0, 2);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle_check(5);

    // Random words of mixed density through a random consumer.
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       word_q.push_back({$urandom, $urandom});
        1:       word_q.push_back({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        default: word_q.push_back((i == 5) ? 64'h0 : (64'd1 << $urandom_range(0, 63)));
      endcase
    end
    run(2, 0);
    idle_check(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_set_bit_enum
